// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI read-side definitions: default bus widths,
//                response and burst encodings, read-responder state type
//                and a byte-lane helper function.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    // System-wide bus width defaults
    localparam int AXI_ADDR_WIDTH_DEF = 32;
    localparam int AXI_DATA_WIDTH_DEF = 32;

    // RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // ARBURST encodings (2'b11 is reserved)
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Read responder states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // log2 of the number of bytes in one data word
    function automatic int bytes_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_addr_gen
//  Description : Combinational AXI burst next-address generator.
//                Given the current beat byte address and the burst
//                attributes, produces the byte address of the following
//                beat. Also flags WRAP bursts whose length is illegal.
//  Ports       : addr_i       current beat byte address
//                size_i       log2 bytes per beat
//                len_i        beats minus one
//                burst_i      burst type
//                next_addr_o  byte address of the next beat
//                wrap_bad_o   WRAP burst with len not in {1,3,7,15}
//  Revision    : 1.0  initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [3:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  wrap_bad_o
);

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_wrap_len;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;

    always_comb begin
        w_incr      = ADDR_WIDTH'(1) << size_i;
        w_size_mask = w_incr - ADDR_WIDTH'(1);
        w_wrap_len  = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
        w_wrap_mask = w_wrap_len - ADDR_WIDTH'(1);

        wrap_bad_o  = (burst_i == BURST_WRAP) &&
                      !(len_i inside {4'd1, 4'd3, 4'd7, 4'd15});

        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            // Aligning before the add makes an unaligned beat 0 fall onto
            // the size grid from beat 1 onward.
            BURST_INCR:  next_addr_o = (addr_i & ~w_size_mask) + w_incr;
            BURST_WRAP:  next_addr_o = (addr_i & ~w_wrap_mask) +
                                       ((addr_i + w_incr) & w_wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule : axi_burst_addr_gen
`default_nettype wire

// File: rtl/axi_rd_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_slave
//  Description : AXI read-channel responder backed by a word-addressed
//                register array. Accepts one AR request at a time and
//                streams the burst on R with registered outputs. The array
//                is loaded through a backdoor write port.
//  Ports       : clk, rst            clock / async active-high reset
//                axi_ar*             read address channel (slave side)
//                axi_r*              read data channel (slave side)
//                bd_we/addr/wdata    backdoor array write
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
    parameter int                        AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
    parameter int                        MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    // Read address channel
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_araddr,
    input  logic [3:0]                    axi_arid,
    input  logic [3:0]                    axi_arlen,
    input  logic [2:0]                    axi_arsize,
    input  logic [1:0]                    axi_arburst,
    input  logic [1:0]                    axi_arlock,
    input  logic [3:0]                    axi_arcache,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    // Read data channel
    output logic [AXI_DATA_WIDTH-1:0]     axi_rdata,
    output logic [3:0]                    axi_rid,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rlast,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    // Backdoor write
    input  logic                          bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]  bd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     bd_wdata
);

    localparam int c_BSHIFT = bytes_shift(AXI_DATA_WIDTH);
    localparam int c_IDX_W  = $clog2(MEM_DEPTH);
    // One extra bit so a window ending at the top of the address map fits
    localparam logic [AXI_ADDR_WIDTH:0] c_MEM_BYTES =
        (AXI_ADDR_WIDTH+1)'(MEM_DEPTH) << c_BSHIFT;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Burst state
    // ------------------------------------------------------------------
    rd_state_e                 state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]                beat_q;
    logic [3:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      slverr_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [3:0]                rid_q;
    logic [1:0]                rresp_q;

    // Address generator inputs: the raw AR request while idle (to form the
    // beat-0 checks), the latched burst attributes while streaming.
    logic [AXI_ADDR_WIDTH-1:0] w_gen_addr;
    logic [2:0]                w_gen_size;
    logic [3:0]                w_gen_len;
    logic [1:0]                w_gen_burst;
    logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
    logic                      w_wrap_bad;

    always_comb begin
        if (state_q == IDLE) begin
            w_gen_addr  = axi_araddr;
            w_gen_size  = axi_arsize;
            w_gen_len   = axi_arlen;
            w_gen_burst = axi_arburst;
        end else begin
            w_gen_addr  = addr_q;
            w_gen_size  = size_q;
            w_gen_len   = len_q;
            w_gen_burst = burst_q;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i      (w_gen_addr),
        .size_i      (w_gen_size),
        .len_i       (w_gen_len),
        .burst_i     (w_gen_burst),
        .next_addr_o (w_next_addr),
        .wrap_bad_o  (w_wrap_bad)
    );

    // ------------------------------------------------------------------
    // Beat load: address, response and data of the beat that the next
    // R-register update will present.
    // ------------------------------------------------------------------
    logic [AXI_ADDR_WIDTH-1:0] load_addr_d;
    logic                      slverr_d;
    logic                      last_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_d;
    logic [1:0]                rresp_d;
    logic [AXI_ADDR_WIDTH-1:0] w_offset;
    logic                      w_in_range;
    logic [c_IDX_W-1:0]        w_word_idx;

    always_comb begin
        if (state_q == IDLE) begin
            load_addr_d = axi_araddr;
            slverr_d    = (axi_arsize > 3'(c_BSHIFT)) ||
                          (axi_arburst == 2'b11) ||
                          w_wrap_bad;
            last_d      = (axi_arlen == 4'd0);
        end else begin
            load_addr_d = w_next_addr;
            slverr_d    = slverr_q;
            last_d      = ((beat_q + 4'd1) == len_q);
        end

        w_offset   = load_addr_d - BASE_ADDR;
        w_in_range = (load_addr_d >= BASE_ADDR) &&
                     ({1'b0, w_offset} < c_MEM_BYTES);
        w_word_idx = c_IDX_W'(w_offset >> c_BSHIFT);

        if (slverr_d) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
        end else if (!w_in_range) begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
        end else begin
            rdata_d = mem_q[w_word_idx];
            rresp_d = RESP_OKAY;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered channel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            beat_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            slverr_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (axi_arvalid && arready_q) begin
                        addr_q    <= axi_araddr;
                        beat_q    <= '0;
                        len_q     <= axi_arlen;
                        size_q    <= axi_arsize;
                        burst_q   <= axi_arburst;
                        slverr_q  <= slverr_d;
                        rid_q     <= axi_arid;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        rlast_q   <= last_d;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (axi_rready) begin
                        if (beat_q == len_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 4'd1;
                            addr_q  <= load_addr_d;
                            rdata_q <= rdata_d;
                            rresp_q <= rresp_d;
                            rlast_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rdata   = rdata_q;
    assign axi_rid     = rid_q;
    assign axi_rresp   = rresp_q;

    // Lock, cache and protection attributes carry no meaning for this target
    logic w_unused_attr;
    assign w_unused_attr = ^{axi_arlock, axi_arcache, axi_arprot};

endmodule : axi_rd_slave
`default_nettype wire

// File: tb/tb_axi_rd_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_slave
//  Description : Directed self-checking bench for axi_rd_slave (32-bit data,
//                BASE_ADDR 0, 256 words). Words 0..7 hold 0xA0..0xA7 and
//                words 254/255 hold 0xB0FE/0xB0FF.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] axi_araddr  = '0;
    logic [3:0]  axi_arid    = '0;
    logic [3:0]  axi_arlen   = '0;
    logic [2:0]  axi_arsize  = '0;
    logic [1:0]  axi_arburst = '0;
    logic [1:0]  axi_arlock  = '0;
    logic [3:0]  axi_arcache = '0;
    logic [2:0]  axi_arprot  = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [3:0]  axi_rid;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready  = 1'b0;
    logic        bd_we       = 1'b0;
    logic [7:0]  bd_addr     = '0;
    logic [31:0] bd_wdata    = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_d  [16];
    logic [1:0]  exp_r  [16];
    logic        rr_pat [16];
    int          rr_n;

    always #5 clk = ~clk;

    axi_rd_slave #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .MEM_DEPTH      (256),
        .BASE_ADDR      (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_araddr  (axi_araddr),
        .axi_arid    (axi_arid),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arlock  (axi_arlock),
        .axi_arcache (axi_arcache),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rid     (axi_rid),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .bd_we       (bd_we),
        .bd_addr     (bd_addr),
        .bd_wdata    (bd_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
        bd_we    = 1'b1;
        bd_addr  = idx;
        bd_wdata = data;
        @(negedge clk);
        bd_we    = 1'b0;
    endtask

    task automatic set_exp(input int i, input logic [31:0] d, input logic [1:0] r);
        exp_d[i] = d;
        exp_r[i] = r;
    endtask

    task automatic rr_always;
        rr_n      = 1;
        rr_pat[0] = 1'b1;
    endtask

    // Issues one AR request, then walks the R beats against exp_d/exp_r
    // using the rready pattern in rr_pat. Called and returning on a negedge.
    task automatic do_burst(input string name, input logic [31:0] addr,
                            input logic [3:0] id, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [1:0] lock);
        int b;
        int cyc;
        @(negedge clk);
        chk({name, "_arready_idle"}, 32'(axi_arready), 32'd1);
        axi_araddr  = addr;
        axi_arid    = id;
        axi_arlen   = len;
        axi_arsize  = size;
        axi_arburst = burst;
        axi_arlock  = lock;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        chk({name, "_arready_busy"}, 32'(axi_arready), 32'd0);
        b   = 0;
        cyc = 0;
        while (b <= int'(len) && cyc < 64) begin
            axi_rready = rr_pat[cyc % rr_n];
            chk($sformatf("%s_b%0d_rvalid", name, b), 32'(axi_rvalid), 32'd1);
            chk($sformatf("%s_b%0d_rdata", name, b), axi_rdata, exp_d[b]);
            chk($sformatf("%s_b%0d_rresp", name, b), 32'(axi_rresp), 32'(exp_r[b]));
            chk($sformatf("%s_b%0d_rid", name, b), 32'(axi_rid), 32'(id));
            chk($sformatf("%s_b%0d_rlast", name, b), 32'(axi_rlast),
                (b == int'(len)) ? 32'd1 : 32'd0);
            if (axi_rready) b++;
            @(negedge clk);
            cyc++;
        end
        axi_rready = 1'b0;
        chk({name, "_beats"}, 32'(b), 32'(len) + 32'd1);
        chk({name, "_rvalid_end"}, 32'(axi_rvalid), 32'd0);
        chk({name, "_rlast_end"}, 32'(axi_rlast), 32'd0);
        chk({name, "_arready_end"}, 32'(axi_arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rr_always();
        // Reset state and preload
        repeat (2) @(negedge clk);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rst_rlast", 32'(axi_rlast), 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk("rst_rid", 32'(axi_rid), 32'd0);
        chk("rst_rresp", 32'(axi_rresp), 32'd0);
        for (int i = 0; i < 8; i++) bd_write(8'(i), 32'hA0 + 32'(i));
        bd_write(8'd254, 32'hB0FE);
        bd_write(8'd255, 32'hB0FF);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arready", 32'(axi_arready), 32'd1);

        // 1: INCR from 0x10
        for (int i = 0; i < 4; i++) set_exp(i, 32'hA4 + 32'(i), 2'b00);
        do_burst("incr", 32'h10, 4'd5, 4'd3, 3'd2, 2'b01, 2'b00);

        // 2: WRAP from 0x18, exclusive request still OKAY
        set_exp(0, 32'hA6, 2'b00); set_exp(1, 32'hA7, 2'b00);
        set_exp(2, 32'hA4, 2'b00); set_exp(3, 32'hA5, 2'b00);
        do_burst("wrap", 32'h18, 4'd2, 4'd3, 3'd2, 2'b10, 2'b01);

        // 3: FIXED, then INCR running off the end of the array
        for (int i = 0; i < 3; i++) set_exp(i, 32'hA2, 2'b00);
        do_burst("fixed", 32'h08, 4'd1, 4'd2, 3'd2, 2'b00, 2'b00);
        set_exp(0, 32'hB0FE, 2'b00); set_exp(1, 32'hB0FF, 2'b00);
        set_exp(2, 32'h0, 2'b11);    set_exp(3, 32'h0, 2'b11);
        do_burst("edge", 32'h3F8, 4'd6, 4'd3, 3'd2, 2'b01, 2'b00);

        // 4: backpressure
        rr_n = 11;
        rr_pat[0] = 1; rr_pat[1] = 0; rr_pat[2]  = 0; rr_pat[3] = 1;
        rr_pat[4] = 0; rr_pat[5] = 1; rr_pat[6]  = 1; rr_pat[7] = 1;
        rr_pat[8] = 1; rr_pat[9] = 1; rr_pat[10] = 1;
        for (int i = 0; i < 8; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
        do_burst("stall", 32'h0, 4'd7, 4'd7, 3'd2, 2'b01, 2'b00);
        rr_always();

        // 5: error responses
        for (int i = 0; i < 3; i++) set_exp(i, 32'h0, 2'b10);
        do_burst("bigsize", 32'h0, 4'd8, 4'd1, 3'd3, 2'b01, 2'b00);
        do_burst("rsvburst", 32'h0, 4'd9, 4'd1, 3'd2, 2'b11, 2'b00);
        do_burst("wraplen", 32'h0, 4'd10, 4'd2, 3'd2, 2'b10, 2'b00);
        set_exp(0, 32'h0, 2'b11);
        do_burst("oob", 32'h400, 4'd11, 4'd0, 3'd2, 2'b01, 2'b00);

        // 6: reset in the middle of a burst
        @(negedge clk);
        axi_araddr = 32'h0; axi_arid = 4'd3; axi_arlen = 4'd7;
        axi_arsize = 3'd2;  axi_arburst = 2'b01; axi_arlock = 2'b00;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_b2_rdata", axi_rdata, 32'hA2);
        rst = 1'b1;
        #1;
        chk("mid_rvalid", 32'(axi_rvalid), 32'd0);
        chk("mid_rlast", 32'(axi_rlast), 32'd0);
        chk("mid_rdata", axi_rdata, 32'd0);
        chk("mid_arready", 32'(axi_arready), 32'd0);
        @(negedge clk);
        axi_rready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_arready", 32'(axi_arready), 32'd1);
        chk("mid_rel_rvalid", 32'(axi_rvalid), 32'd0);
        set_exp(0, 32'hA0, 2'b00);
        do_burst("after_rst", 32'h0, 4'd4, 4'd0, 3'd2, 2'b01, 2'b00);

        // 7: backdoor write to the word being presented leaves the beat alone
        @(negedge clk);
        axi_araddr = 32'h1C; axi_arid = 4'd12; axi_arlen = 4'd0;
        axi_arsize = 3'd2;   axi_arburst = 2'b01;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        bd_write(8'd7, 32'hC7);
        chk("bd_hold_rdata", axi_rdata, 32'hA7);
        chk("bd_hold_rvalid", 32'(axi_rvalid), 32'd1);
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        chk("bd_hold_done", 32'(axi_rvalid), 32'd0);
        set_exp(0, 32'hC7, 2'b00);
        do_burst("bd_new", 32'h1C, 4'd13, 4'd0, 3'd2, 2'b01, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_axi_rd_slave
`default_nettype wire
